dffram_port_arbiter: RTL and testbench

- Shares one single-port DFFRAM macro between the core instruction port and the UART boot programmer's write port.
- Programmer writes are buffered in a small FIFO, because the programmer has no ready/stall input. They are drained with priority, and a streak limit guarantees the core a slot.
- Generates the core's grant and read-valid. Sits between the core's instruction RAM port and the instruction DFFRAM in the top-level wrapper.

---
 rtl/dffram_arb_pkg.sv | 26 ++
 rtl/dffram_port_arbiter_prog_wr_fifo.sv | 48 ++++
 rtl/dffram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_dffram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_arb_pkg.sv
// Shared types and helpers for the DFFRAM port arbiter.
// Holds the arbitration state enum, programmer write bundle and mask helper.
package dffram_arb_pkg;

  localparam int ARB_ADDR_W = 8;

  typedef enum logic {
    PROG_PRI,
    CORE_PRI
  } arb_state_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [31:0]           data;
  } prog_wr_t;

  // A byte lane is written when any bit of its mask byte is set
  function automatic logic [3:0] mask_to_be(input logic [31:0] m);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) begin
      be[k] = |m[8*k +: 8];
    end
    return be;
  endfunction

endpackage

// File: rtl/dffram_port_arbiter_prog_wr_fifo.sv
// Synchronous FIFO buffering programmer writes.
// Push while full is accepted only when a pop happens on the same edge.
module prog_wr_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/dffram_port_arbiter.sv
// Shares one DFFRAM between the core port and the buffered boot programmer.
// Optional perf counters are enabled with DFFRAM_ARB_PERF_EN.
module dffram_port_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [31:0]       core_wmask_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [31:0]       prog_wdata_i,
  output logic              prog_busy_o,
  output logic              prog_ovf_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  input  logic [31:0]       ram_do_i
`ifdef DFFRAM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_core_stall_o,
  output logic [15:0]       perf_prog_grant_o
`endif
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [SW-1:0]   streak;
  logic [SW-1:0]   streak_nxt;
  logic            prog_gnt;
  logic            core_gnt;
  logic            fifo_full;
  logic            fifo_empty;
  prog_wr_t        wr_in;
  prog_wr_t        head;

  assign wr_in = '{addr: ARB_ADDR_W'(prog_addr_i), data: prog_wdata_i};

  prog_wr_fifo #(
    .W     ($bits(prog_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (prog_we_i),
    .pop   (prog_gnt),
    .din   (wr_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    prog_gnt   = 1'b0;
    core_gnt   = 1'b0;
    state_nxt  = PROG_PRI;
    streak_nxt = streak;
    if (!rst_i) begin
      unique case (state)
        PROG_PRI: begin
          if (!fifo_empty) prog_gnt = 1'b1;
          else             core_gnt = core_req_i;
        end
        CORE_PRI: begin
          if (core_req_i) core_gnt = 1'b1;
          else            prog_gnt = !fifo_empty;
        end
      endcase
    end
    if (core_gnt || !core_req_i) streak_nxt = '0;
    else if (prog_gnt)           streak_nxt = streak + SW'(1);
    // Streak exhausted: the core owns the next slot
    if (streak_nxt == SW'(MAX_STREAK)) begin
      state_nxt  = CORE_PRI;
      streak_nxt = '0;
    end
  end

  always_comb begin
    ram_en_o = prog_gnt || core_gnt;
    ram_we_o = '0;
    ram_a_o  = '0;
    ram_di_o = '0;
    if (prog_gnt) begin
      ram_we_o = 4'hF;
      ram_a_o  = ADDR_W'(head.addr);
      ram_di_o = head.data;
    end else if (core_gnt) begin
      ram_we_o = core_we_i ? mask_to_be(core_wmask_i) : 4'h0;
      ram_a_o  = core_addr_i;
      ram_di_o = core_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= PROG_PRI;
      streak        <= '0;
      core_rvalid_o <= 1'b0;
      prog_ovf_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      streak        <= streak_nxt;
      core_rvalid_o <= core_gnt && !core_we_i;
      if (prog_we_i && fifo_full && !prog_gnt) prog_ovf_o <= 1'b1;
    end
  end

  assign core_gnt_o   = core_gnt;
  assign core_rdata_o = ram_do_i;
  assign prog_busy_o  = !fifo_empty;

`ifdef DFFRAM_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_core_stall_o <= '0;
      perf_prog_grant_o <= '0;
    end else begin
      if (core_req_i && !core_gnt && perf_core_stall_o != 16'hFFFF)
        perf_core_stall_o <= perf_core_stall_o + 16'd1;
      if (prog_gnt && perf_prog_grant_o != 16'hFFFF)
        perf_prog_grant_o <= perf_prog_grant_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Scoreboard bench for dffram_port_arbiter with a behavioural DFFRAM.
// Expected RAM accesses and read data are queued; a monitor checks them.
module tb_dffram_port_arbiter;

  typedef struct packed {
    logic        gnt;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_wmask;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        prog_busy_o;
  logic        prog_ovf_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [7:0]  ram_a_o;
  logic [31:0] ram_di_o;
  logic [31:0] ram_do;

  logic [31:0] mem [256];
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  exp_t        mon_e;
  logic [31:0] mon_d;
  int          tests = 0;
  int          fails = 0;

  dffram_port_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_addr_i   (core_addr),
    .core_wdata_i  (core_wdata),
    .core_wmask_i  (core_wmask),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .prog_we_i     (prog_we),
    .prog_addr_i   (prog_addr),
    .prog_wdata_i  (prog_wdata),
    .prog_busy_o   (prog_busy_o),
    .prog_ovf_o    (prog_ovf_o),
    .ram_en_o      (ram_en_o),
    .ram_we_o      (ram_we_o),
    .ram_a_o       (ram_a_o),
    .ram_di_o      (ram_di_o),
    .ram_do_i      (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    ram_do = '0;
  end

  // DFFRAM model: read-before-write, one cycle read latency
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_do <= mem[ram_a_o];
      for (int k = 0; k < 4; k++)
        if (ram_we_o[k]) mem[ram_a_o][8*k +: 8] <= ram_di_o[8*k +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ram_unexpected: got a=%h we=%h expected none",
                   ram_a_o, ram_we_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ram_gnt", 32'(core_gnt_o), 32'(mon_e.gnt));
          chk("ram_we", 32'(ram_we_o), 32'(mon_e.we));
          chk("ram_a", 32'(ram_a_o), 32'(mon_e.a));
          chk("ram_di", ram_di_o, mon_e.di);
        end
      end
      if (core_rvalid_o) begin
        if (rd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rvalid_unexpected: got data=%h expected none",
                   core_rdata_o);
        end else begin
          mon_d = rd_q.pop_front();
          chk("rdata", core_rdata_o, mon_d);
        end
      end
    end
  end

  function automatic exp_t pw(input logic [7:0] a);
    return '{gnt: 1'b0, we: 4'hF, a: a, di: 32'hC0DE_0000 + {24'h0, a}};
  endfunction

  function automatic exp_t cr(input logic [7:0] a);
    return '{gnt: 1'b1, we: 4'h0, a: a, di: 32'h0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Programmer writes every cycle; core requests from the second cycle on
  task automatic stream(input int n, input logic [7:0] base,
                        input logic [7:0] ra);
    for (int i = 0; i < n; i++) begin
      prog_we    = 1'b1;
      prog_addr  = base + 8'(i);
      prog_wdata = 32'hC0DE_0000 + {24'h0, base + 8'(i)};
      core_req   = (i > 0);
      core_we    = 1'b0;
      core_addr  = (i <= 5) ? ra : ra + 8'd1;
      #1;
      chk($sformatf("streak_gnt%0d", i), 32'(core_gnt_o),
          32'(i == 5 || i == 10));
      tick();
    end
    prog_we  = 1'b0;
    core_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    core_wmask = '0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(ram_en_o), 32'h0);
    chk("rst_we", 32'(ram_we_o), 32'h0);
    chk("rst_a", 32'(ram_a_o), 32'h0);
    chk("rst_di", ram_di_o, 32'h0);
    chk("rst_rvalid", 32'(core_rvalid_o), 32'h0);
    chk("rst_busy", 32'(prog_busy_o), 32'h0);
    chk("rst_ovf", 32'(prog_ovf_o), 32'h0);
    rst = 1'b0;
    tick();

    // idle core read
    exp_q.push_back(cr(8'h10));
    rd_q.push_back(32'hA000_0010);
    core_req  = 1'b1;
    core_addr = 8'h10;
    #1;
    chk("idle_gnt", 32'(core_gnt_o), 32'h1);
    chk("idle_en", 32'(ram_en_o), 32'h1);
    tick();
    core_req = 1'b0;
    chk("idle_rvalid", 32'(core_rvalid_o), 32'h1);
    tick();
    chk("idle_rvalid_drop", 32'(core_rvalid_o), 32'h0);

    // programmer priority over a waiting core
    exp_q.push_back('{gnt: 1'b0, we: 4'hF, a: 8'h05, di: 32'hDEADBEEF});
    exp_q.push_back(cr(8'h05));
    rd_q.push_back(32'hDEADBEEF);
    prog_we    = 1'b1;
    prog_addr  = 8'h05;
    prog_wdata = 32'hDEADBEEF;
    tick();
    prog_we   = 1'b0;
    core_req  = 1'b1;
    core_addr = 8'h05;
    #1;
    chk("prio_core_wait", 32'(core_gnt_o), 32'h0);
    chk("prio_we", 32'(ram_we_o), 32'hF);
    chk("prio_a", 32'(ram_a_o), 32'h05);
    tick();
    chk("prio_core_gnt", 32'(core_gnt_o), 32'h1);
    tick();
    core_req = 1'b0;

    // byte mask write then read back
    exp_q.push_back('{gnt: 1'b1, we: 4'b0100, a: 8'h30, di: 32'h12345678});
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 8'h30;
    core_wdata = 32'h12345678;
    core_wmask = 32'h00FF_0000;
    #1;
    chk("mask_we", 32'(ram_we_o), 32'h4);
    tick();
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_wmask = '0;
    core_wdata = '0;
    chk("mask_no_rvalid", 32'(core_rvalid_o), 32'h0);
    exp_q.push_back(cr(8'h30));
    rd_q.push_back(32'hA034_0030);
    core_req = 1'b1;
    tick();
    core_req = 1'b0;
    tick();

    // streak fairness then overflow in the second core slot
    for (int i = 0; i < 4; i++) exp_q.push_back(pw(8'h40 + 8'(i)));
    exp_q.push_back(cr(8'h80));
    for (int i = 4; i < 8; i++) exp_q.push_back(pw(8'h40 + 8'(i)));
    exp_q.push_back(cr(8'h81));
    exp_q.push_back(pw(8'h48));
    exp_q.push_back(pw(8'h49));
    rd_q.push_back(32'hA000_0080);
    rd_q.push_back(32'hA000_0081);
    stream(11, 8'h40, 8'h80);
    chk("ovf_set", 32'(prog_ovf_o), 32'h1);
    chk("ovf_busy", 32'(prog_busy_o), 32'h1);
    repeat (3) tick();
    chk("ovf_sticky", 32'(prog_ovf_o), 32'h1);
    chk("ovf_drained", 32'(prog_busy_o), 32'h0);
    chk("ovf_dropped_mem", mem[8'h4A], 32'hA000_004A);

    // reset while two writes are still queued
    for (int i = 0; i < 4; i++) exp_q.push_back(pw(8'h60 + 8'(i)));
    exp_q.push_back(cr(8'h90));
    stream(6, 8'h60, 8'h90);
    #1;
    chk("drain_busy", 32'(prog_busy_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(ram_en_o), 32'h0);
    chk("midrst_we", 32'(ram_we_o), 32'h0);
    chk("midrst_a", 32'(ram_a_o), 32'h0);
    chk("midrst_di", ram_di_o, 32'h0);
    chk("midrst_busy", 32'(prog_busy_o), 32'h0);
    chk("midrst_ovf", 32'(prog_ovf_o), 32'h0);
    chk("midrst_rvalid", 32'(core_rvalid_o), 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("postrst_busy", 32'(prog_busy_o), 32'h0);
    chk("postrst_mem64", mem[8'h64], 32'hA000_0064);
    chk("postrst_mem65", mem[8'h65], 32'hA000_0065);

    chk("exp_q_left", 32'(exp_q.size()), 32'h0);
    chk("rd_q_left", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
